// File: rtl/id_operand_stage_if.sv
// Bundle of every non-clock/reset signal of the ID operand stage.
// Master = surrounding pipeline (drives fetch, stall, regfile and forwarding data); slave = ID stage.
interface id_operand_stage_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3,
  parameter int STALL_W = 6
);
  localparam int FWD_W = NUM_FWD * (2 + REG_AW + DATA_W);

  // No valid/ready pair: *_ce signals are qualifiers only, and stall[k]=1 means stage k must hold.
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               if_ce_i;
  logic [31:0]        if_pc_i;
  logic [31:0]        inst_i;
  logic [DATA_W-1:0]  rf_rdata1_i;
  logic [DATA_W-1:0]  rf_rdata2_i;
  logic               rs_used_i;
  logic               rt_used_i;
  logic [FWD_W-1:0]   fwd_bus_i;
  logic               id_ce_o;
  logic [31:0]        id_pc_o;
  logic [31:0]        inst_o;
  logic [DATA_W-1:0]  rs_val_o;
  logic [DATA_W-1:0]  rt_val_o;
  logic               stallreq_o;
  logic               br_e_o;
  logic [31:0]        br_addr_o;
  logic               hold_valid_o;

  modport master (
    output stall, flush, if_ce_i, if_pc_i, inst_i, rf_rdata1_i, rf_rdata2_i,
           rs_used_i, rt_used_i, fwd_bus_i,
    input  id_ce_o, id_pc_o, inst_o, rs_val_o, rt_val_o, stallreq_o,
           br_e_o, br_addr_o, hold_valid_o
  );

  modport slave (
    input  stall, flush, if_ce_i, if_pc_i, inst_i, rf_rdata1_i, rf_rdata2_i,
           rs_used_i, rt_used_i, fwd_bus_i,
    output id_ce_o, id_pc_o, inst_o, rs_val_o, rt_val_o, stallreq_o,
           br_e_o, br_addr_o, hold_valid_o
  );
endinterface

// File: rtl/id_operand_stage.sv
// MIPS ID stage: IF->ID register with stall-safe instruction hold, prioritised operand
// forwarding, load-use stall detection and branch/jump resolution on forwarded operands.
module id_operand_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 1,
  parameter int STALL_W  = 6
) (
  input logic clk,
  input logic rst,
  id_operand_stage_if.slave bus
);
  localparam int E = 2 + REG_AW + DATA_W;

  logic        ce_q, ce_d;
  logic [31:0] pc_q, pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_inst_q, hold_inst_d;

  logic stop1, stop2;
  assign stop1 = bus.stall[1];
  assign stop2 = bus.stall[2];

  logic unused_stall_bits;
  assign unused_stall_bits = ^{bus.stall[STALL_W-1:3], bus.stall[0]};

  always_comb begin
    ce_d         = ce_q;
    pc_d         = pc_q;
    hold_valid_d = hold_valid_q;
    hold_inst_d  = hold_inst_q;
    if (bus.flush) begin
      ce_d = 1'b0;
      pc_d = '0;
    end else if (stop1 && !stop2) begin
      ce_d = 1'b0;
      pc_d = '0;
    end else if (!stop1) begin
      ce_d = bus.if_ce_i;
      pc_d = bus.if_pc_i;
    end
    // The SRAM output only reflects the held PC for one cycle, so freeze it on the first stall cycle.
    if (bus.flush || !stop1) begin
      hold_valid_d = 1'b0;
    end else if (!hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_inst_d  = bus.inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q         <= 1'b0;
      pc_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_inst_q  <= '0;
    end else begin
      ce_q         <= ce_d;
      pc_q         <= pc_d;
      hold_valid_q <= hold_valid_d;
      hold_inst_q  <= hold_inst_d;
    end
  end

  logic [31:0] inst;
  assign inst = ce_q ? (hold_valid_q ? hold_inst_q : bus.inst_i) : 32'd0;

  logic [REG_AW-1:0] rs_addr, rt_addr;
  assign rs_addr = inst[21 +: REG_AW];
  assign rt_addr = inst[16 +: REG_AW];

  logic              fwd_we   [NUM_FWD];
  logic              fwd_ld   [NUM_FWD];
  logic [REG_AW-1:0] fwd_addr [NUM_FWD];
  logic [DATA_W-1:0] fwd_data [NUM_FWD];

  always_comb begin
    for (int k = 0; k < NUM_FWD; k++) begin
      fwd_data[k] = bus.fwd_bus_i[k*E +: DATA_W];
      fwd_addr[k] = bus.fwd_bus_i[k*E + DATA_W +: REG_AW];
      fwd_ld[k]   = bus.fwd_bus_i[k*E + DATA_W + REG_AW];
      fwd_we[k]   = bus.fwd_bus_i[k*E + DATA_W + REG_AW + 1];
    end
  end

  logic [DATA_W-1:0] rs_val, rt_val;
  logic              rs_haz, rt_haz;

  // Walk oldest to youngest so the youngest match wins; its load flag decides the hazard.
  always_comb begin
    rs_val = bus.rf_rdata1_i;
    rt_val = bus.rf_rdata2_i;
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_addr[k] == rs_addr)) begin
        rs_val = fwd_data[k];
        rs_haz = fwd_ld[k] && (k < LOAD_LAT);
      end
      if (fwd_we[k] && (fwd_addr[k] == rt_addr)) begin
        rt_val = fwd_data[k];
        rt_haz = fwd_ld[k] && (k < LOAD_LAT);
      end
    end
    if (rs_addr == '0) begin
      rs_val = '0;
      rs_haz = 1'b0;
    end
    if (rt_addr == '0) begin
      rt_val = '0;
      rt_haz = 1'b0;
    end
  end

  logic stallreq;
  assign stallreq = ce_q & ((bus.rs_used_i & rs_haz) | (bus.rt_used_i & rt_haz));

  logic [5:0]  opcode, funct;
  logic [4:0]  rt_field;
  logic [31:0] pc_plus4, cond_target, jump_target;
  logic        rs_neg, rs_zero;

  assign opcode      = inst[31:26];
  assign funct       = inst[5:0];
  assign rt_field    = inst[20:16];
  assign pc_plus4    = pc_q + 32'd4;
  assign cond_target = pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00};
  assign jump_target = {pc_plus4[31:28], inst[25:0], 2'b00};
  assign rs_neg      = rs_val[DATA_W-1];
  assign rs_zero     = (rs_val == '0);

  logic        taken;
  logic [31:0] target;

  always_comb begin
    taken  = 1'b0;
    target = cond_target;
    case (opcode)
      6'b000000: begin
        if (funct == 6'b001000 || funct == 6'b001001) begin
          taken  = 1'b1;
          target = 32'(rs_val);
        end
      end
      6'b000001: begin
        case (rt_field)
          5'b00000, 5'b10000: taken = rs_neg;
          5'b00001, 5'b10001: taken = !rs_neg;
          default:            taken = 1'b0;
        endcase
      end
      6'b000010, 6'b000011: begin
        taken  = 1'b1;
        target = jump_target;
      end
      6'b000100: taken = (rs_val == rt_val);
      6'b000101: taken = (rs_val != rt_val);
      6'b000110: taken = rs_neg || rs_zero;
      6'b000111: taken = !rs_neg && !rs_zero;
      default:   taken = 1'b0;
    endcase
  end

  logic br_e;
  assign br_e = ce_q & ~stallreq & taken;

  assign bus.id_ce_o      = ce_q;
  assign bus.id_pc_o      = pc_q;
  assign bus.inst_o       = inst;
  assign bus.rs_val_o     = rs_val;
  assign bus.rt_val_o     = rt_val;
  assign bus.stallreq_o   = stallreq;
  assign bus.br_e_o       = br_e;
  assign bus.br_addr_o    = br_e ? target : 32'd0;
  assign bus.hold_valid_o = hold_valid_q;
endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model of the ID stage.
module tb_id_operand_stage;
  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_FWD  = 3;
  localparam int LOAD_LAT = 1;
  localparam int STALL_W  = 6;
  localparam int E        = 2 + REG_AW + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_operand_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .STALL_W(STALL_W)) bus ();

  id_operand_stage #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .LOAD_LAT(LOAD_LAT), .STALL_W(STALL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // forwarding entries as plain arrays; the bus vector is packed from them
  logic        f_we   [NUM_FWD];
  logic        f_ld   [NUM_FWD];
  logic [4:0]  f_addr [NUM_FWD];
  logic [31:0] f_data [NUM_FWD];

  // ---------------- reference model state ----------------
  logic        m_ce = 1'b0;
  logic        m_hv = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_hold = '0;

  always @(posedge clk) begin
    if (rst || bus.flush) begin
      m_ce <= 1'b0;
      m_pc <= '0;
      m_hv <= 1'b0;
    end else if (!bus.stall[1]) begin
      m_ce <= bus.if_ce_i;
      m_pc <= bus.if_pc_i;
      m_hv <= 1'b0;
    end else begin
      if (!bus.stall[2]) begin
        m_ce <= 1'b0;
        m_pc <= '0;
      end
      if (!m_hv) begin
        m_hv   <= 1'b1;
        m_hold <= bus.inst_i;
      end
    end
  end

  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rfv,
                                          output logic hazard);
    hazard = 1'b0;
    if (a == 5'd0) return 32'd0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (f_we[k] && f_addr[k] == a) begin
        hazard = f_ld[k] && (k < LOAD_LAT);
        return f_data[k];
      end
    end
    return rfv;
  endfunction

  function automatic void branch_model(input logic [31:0] inst, input logic [31:0] pc,
                                       input logic [31:0] rs, input logic [31:0] rt,
                                       output logic taken, output logic [31:0] tgt);
    int op, fn, sub, srs, off;
    logic [31:0] pc4, cond_t;
    op  = int'(inst[31:26]);
    fn  = int'(inst[5:0]);
    sub = int'(inst[20:16]);
    srs = $signed(rs);
    off = $signed(inst[15:0]);
    pc4 = pc + 32'd4;
    cond_t = pc4 + 32'(off * 4);
    taken = 1'b0;
    tgt   = 32'd0;
    case (op)
      0: if (fn == 8 || fn == 9) begin taken = 1'b1; tgt = rs; end
      1: begin
        if (sub == 0 || sub == 16) taken = (srs < 0);
        if (sub == 1 || sub == 17) taken = (srs >= 0);
        tgt = cond_t;
      end
      2, 3: begin taken = 1'b1; tgt = (pc4 & 32'hF000_0000) | (32'(inst[25:0]) << 2); end
      4: begin taken = (rs == rt); tgt = cond_t; end
      5: begin taken = (rs != rt); tgt = cond_t; end
      6: begin taken = (srs <= 0); tgt = cond_t; end
      7: begin taken = (srs > 0);  tgt = cond_t; end
      default: taken = 1'b0;
    endcase
  endfunction

  task automatic compute_exp(output logic [31:0] e_inst, e_rs, e_rt, e_addr,
                             output logic e_stall, e_bre);
    logic hz_rs, hz_rt, taken;
    logic [31:0] tgt;
    e_inst  = !m_ce ? 32'd0 : (m_hv ? m_hold : bus.inst_i);
    e_rs    = resolve(e_inst[25:21], bus.rf_rdata1_i, hz_rs);
    e_rt    = resolve(e_inst[20:16], bus.rf_rdata2_i, hz_rt);
    e_stall = m_ce && ((bus.rs_used_i && hz_rs) || (bus.rt_used_i && hz_rt));
    branch_model(e_inst, m_pc, e_rs, e_rt, taken, tgt);
    e_bre   = m_ce && !e_stall && taken;
    e_addr  = e_bre ? tgt : 32'd0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      logic [31:0] e_inst, e_rs, e_rt, e_addr;
      logic e_stall, e_bre;
      compute_exp(e_inst, e_rs, e_rt, e_addr, e_stall, e_bre);
      chk("m_id_ce",    32'(bus.id_ce_o),      32'(m_ce));
      chk("m_id_pc",    bus.id_pc_o,           m_pc);
      chk("m_hold_vld", 32'(bus.hold_valid_o), 32'(m_hv));
      chk("m_inst",     bus.inst_o,            e_inst);
      chk("m_rs_val",   bus.rs_val_o,          e_rs);
      chk("m_rt_val",   bus.rt_val_o,          e_rt);
      chk("m_stallreq", 32'(bus.stallreq_o),   32'(e_stall));
      chk("m_br_e",     32'(bus.br_e_o),       32'(e_bre));
      chk("m_br_addr",  bus.br_addr_o,         e_addr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_fwd();
    logic [NUM_FWD*E-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_FWD; k++) v[k*E +: E] = {f_we[k], f_ld[k], f_addr[k], f_data[k]};
    bus.fwd_bus_i = v;
  endtask

  task automatic clear_fwd();
    for (int k = 0; k < NUM_FWD; k++) begin
      f_we[k] = 1'b0; f_ld[k] = 1'b0; f_addr[k] = 5'd0; f_data[k] = 32'd0;
    end
    pack_fwd();
  endtask

  task automatic set_fwd(input int k, input logic ld, input logic [4:0] a, input logic [31:0] d);
    f_we[k] = 1'b1; f_ld[k] = ld; f_addr[k] = a; f_data[k] = d;
    pack_fwd();
  endtask

  task automatic load_id(input logic [31:0] pc);
    bus.stall   = '0;
    bus.flush   = 1'b0;
    bus.if_ce_i = 1'b1;
    bus.if_pc_i = pc;
    step();
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [4:0]  rs  = 5'($urandom_range(0, 7));
    logic [4:0]  rt  = 5'($urandom_range(0, 7));
    logic [15:0] imm = 16'($urandom);
    case ($urandom_range(0, 13))
      0:  return {6'd4, rs, rt, imm};
      1:  return {6'd5, rs, rt, imm};
      2:  return {6'd6, rs, 5'd0, imm};
      3:  return {6'd7, rs, 5'd0, imm};
      4:  return {6'd1, rs, 5'd0, imm};
      5:  return {6'd1, rs, 5'd1, imm};
      6:  return {6'd1, rs, 5'd16, imm};
      7:  return {6'd1, rs, 5'd17, imm};
      8:  return {6'd2, 26'($urandom)};
      9:  return {6'd3, 26'($urandom)};
      10: return {6'd0, rs, 15'd0, 6'h08};
      11: return {6'd0, rs, 5'd0, 5'd31, 5'd0, 6'h09};
      12: return {6'd0, rs, rt, 5'd9, 5'd0, 6'h21};
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] BEQ_R4_R5 = {6'd4, 5'd4, 5'd5, 16'd3};
  localparam logic [31:0] INST_A    = 32'h0085_1021;
  localparam logic [31:0] INST_B    = 32'h3C01_ABCD;
  localparam logic [31:0] INST_C    = 32'h8C22_0010;

  // ---------------- stimulus ----------------
  initial begin
    bus.stall = '0; bus.flush = 1'b0; bus.if_ce_i = 1'b0; bus.if_pc_i = '0;
    bus.inst_i = '0; bus.rf_rdata1_i = '0; bus.rf_rdata2_i = '0;
    bus.rs_used_i = 1'b0; bus.rt_used_i = 1'b0;
    clear_fwd();
    rst = 1'b1;
    step();
    check_en = 1'b1;
    chk("rst_id_ce", 32'(bus.id_ce_o), 32'd0);
    chk("rst_inst", bus.inst_o, 32'd0);
    chk("rst_br_addr", bus.br_addr_o, 32'd0);
    chk("rst_hold_vld", 32'(bus.hold_valid_o), 32'd0);
    step();
    rst = 1'b0;

    // forwarding priority: youngest matching entry wins
    load_id(32'h100);
    bus.inst_i = {6'd0, 5'd8, 5'd0, 5'd9, 5'd0, 6'h21};
    bus.rs_used_i = 1'b1; bus.rt_used_i = 1'b1;
    bus.rf_rdata1_i = 32'hAAAA; bus.rf_rdata2_i = 32'd0;
    set_fwd(0, 1'b0, 5'd8, 32'h11);
    set_fwd(2, 1'b0, 5'd8, 32'h33);
    #1;
    chk("fwd_prio_e0", bus.rs_val_o, 32'h11);
    chk("fwd_id_pc", bus.id_pc_o, 32'h100);
    f_we[0] = 1'b0; pack_fwd();
    #1;
    chk("fwd_prio_e2", bus.rs_val_o, 32'h33);

    // $0 is never forwarded
    step();
    clear_fwd();
    bus.inst_i = {6'd0, 5'd0, 5'd8, 5'd9, 5'd0, 6'h21};
    bus.rf_rdata1_i = 32'h1234;
    set_fwd(0, 1'b0, 5'd0, 32'hDEAD);
    #1;
    chk("zero_guard", bus.rs_val_o, 32'd0);

    // load-use: stall while load is youngest, resolve once it ages one slot
    step();
    clear_fwd();
    bus.inst_i = BEQ_R4_R5;
    bus.rf_rdata1_i = 32'd0; bus.rf_rdata2_i = 32'd7;
    set_fwd(0, 1'b1, 5'd4, 32'd7);
    #1;
    chk("lu_stallreq", 32'(bus.stallreq_o), 32'd1);
    chk("lu_br_e_blocked", 32'(bus.br_e_o), 32'd0);
    bus.stall = 6'b000111;
    step();
    bus.stall = '0;
    bus.inst_i = 32'hFFFF_FFFF;
    clear_fwd();
    set_fwd(1, 1'b1, 5'd4, 32'd7);
    #1;
    chk("lu_inst_held", bus.inst_o, BEQ_R4_R5);
    chk("lu_stall_gone", 32'(bus.stallreq_o), 32'd0);
    chk("lu_br_e", 32'(bus.br_e_o), 32'd1);
    chk("lu_br_addr", bus.br_addr_o, 32'h110);

    // instruction hold across a 3-cycle stall
    load_id(32'h200);
    clear_fwd();
    bus.if_pc_i = 32'h204;
    bus.stall = 6'b000111;
    bus.inst_i = INST_A;
    #1 chk("hold_c1", bus.inst_o, INST_A);
    step();
    bus.inst_i = INST_B;
    #1 chk("hold_c2", bus.inst_o, INST_A);
    chk("hold_pc", bus.id_pc_o, 32'h200);
    step();
    bus.inst_i = INST_C;
    #1 chk("hold_c3", bus.inst_o, INST_A);
    step();
    bus.stall = '0;
    #1 chk("hold_release", bus.inst_o, INST_A);
    step();
    chk("hold_new_pc", bus.id_pc_o, 32'h204);
    chk("hold_follow", bus.inst_o, INST_C);

    // signed REGIMM/blez/bgtz and jr with a forwarded target
    load_id(32'h300);
    clear_fwd();
    bus.rf_rdata1_i = 32'h8000_0000;
    bus.rs_used_i = 1'b1; bus.rt_used_i = 1'b0;
    bus.inst_i = {6'd1, 5'd3, 5'd0, 16'd1};
    #1 chk("bltz_taken", 32'(bus.br_e_o), 32'd1);
    chk("bltz_addr", bus.br_addr_o, 32'h308);
    bus.inst_i = {6'd1, 5'd3, 5'd1, 16'd1};
    #1 chk("bgez_not", 32'(bus.br_e_o), 32'd0);
    step();
    bus.inst_i = {6'd6, 5'd3, 5'd0, 16'd1};
    #1 chk("blez_taken", 32'(bus.br_e_o), 32'd1);
    bus.inst_i = {6'd7, 5'd3, 5'd0, 16'd1};
    #1 chk("bgtz_not", 32'(bus.br_e_o), 32'd0);
    step();
    bus.inst_i = {6'd0, 5'd3, 15'd0, 6'h08};
    set_fwd(0, 1'b0, 5'd3, 32'h1FC0_0040);
    #1 chk("jr_addr", bus.br_addr_o, 32'h1FC0_0040);

    // reset in the middle of a 2-cycle stall
    clear_fwd();
    bus.stall = 6'b000111;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_stall_ce", 32'(bus.id_ce_o), 32'd0);
    chk("rst_stall_inst", bus.inst_o, 32'd0);
    chk("rst_stall_hold", 32'(bus.hold_valid_o), 32'd0);
    load_id(32'h400);
    bus.inst_i = 32'h1234_5678;
    #1 chk("post_rst_follow", bus.inst_o, 32'h1234_5678);

    // flush with a valid instruction, then flush during a load-use stall
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.stall = 6'b000111;
    chk("flush_ce", 32'(bus.id_ce_o), 32'd0);
    chk("flush_inst", bus.inst_o, 32'd0);
    load_id(32'h500);
    bus.inst_i = BEQ_R4_R5;
    bus.rs_used_i = 1'b1; bus.rt_used_i = 1'b1;
    set_fwd(0, 1'b1, 5'd4, 32'd7);
    #1 chk("flush_lu_pre", 32'(bus.stallreq_o), 32'd1);
    bus.flush = 1'b1;
    bus.stall = 6'b000111;
    step();
    bus.flush = 1'b0;
    chk("flush_lu_post", 32'(bus.stallreq_o), 32'd0);
    bus.stall = '0;

    // randomized traffic; the negedge scoreboard checks every cycle
    for (int i = 0; i < 3000; i++) begin
      logic s1, s2;
      step();
      rst       = ($urandom_range(0, 63) == 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      s1 = ($urandom_range(0, 3) == 0);
      s2 = s1 ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.stall       = {3'($urandom), s2, s1, 1'($urandom)};
      bus.if_ce_i     = ($urandom_range(0, 7) != 0);
      bus.if_pc_i     = $urandom & 32'hFFFF_FFFC;
      bus.inst_i      = gen_inst();
      bus.rf_rdata1_i = rand_val();
      bus.rf_rdata2_i = rand_val();
      bus.rs_used_i   = 1'($urandom_range(0, 1));
      bus.rt_used_i   = 1'($urandom_range(0, 1));
      for (int k = 0; k < NUM_FWD; k++) begin
        f_we[k]   = ($urandom_range(0, 2) != 0);
        f_ld[k]   = ($urandom_range(0, 3) == 0);
        f_addr[k] = 5'($urandom_range(0, 7));
        f_data[k] = rand_val();
      end
      pack_fwd();
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised decode-stage operand and branch unit for the 5-stage MIPS pipeline, placed between IF and EX. It holds the IF→ID pipeline register and keeps the fetched instruction stable across stalls. It resolves rs/rt through a configurable number of prioritised forwarding sources, detects load-use hazards against a configurable load latency, and resolves all conditional and unconditional branches/jumps in ID using forwarded operands.

## Interface
- DATA_W, 32, datapath and register width
- REG_AW, 5, register address width
- NUM_FWD, 3, forwarding sources; entry 0 = youngest (EX), highest priority
- LOAD_LAT, 1, loads whose entry index < LOAD_LAT have no data yet
- STALL_W, 6, stall bus width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  STALL_W  pipeline stall bus; Stop=1, NoStop=0
- flush  in  1  kill ID contents (exception path)
- if_ce_i  in  1  fetch valid
- if_pc_i  in  32  fetch PC
- inst_i  in  32  instruction SRAM read data for the PC held in ID
- rf_rdata1_i, rf_rdata2_i  in  DATA_W  regfile reads of inst[25:21], inst[20:16]
- rs_used_i, rt_used_i  in  1  decoder flags: instruction consumes rs / rt
- fwd_bus_i  in  NUM_FWD*(2+REG_AW+DATA_W)  entry k at [k*E +: E], fields MSB-first {we, is_load, waddr, wdata}
- id_ce_o  out  1  ID valid
- id_pc_o  out  32  ID PC
- inst_o  out  32  stable instruction
- rs_val_o, rt_val_o  out  DATA_W  resolved operands
- stallreq_o  out  1  load-use stall request
- br_e_o  out  1  redirect taken
- br_addr_o  out  32  redirect target

## Operation
- Pipeline register {ce, pc}: rst or flush → 0; else stall[1]=Stop & stall[2]=NoStop → 0 (bubble); else stall[1]=NoStop → load {if_ce_i, if_pc_i}; else hold.
- Instruction hold: when stall[1]=Stop and hold_valid=0, capture inst_i and set hold_valid. Clear on stall[1]=NoStop, flush or rst. inst_o = hold_valid ? hold_inst : inst_i. When id_ce_o=0, inst_o is forced to 0 (nop).
- Operand resolution, per source s ∈ {rs, rt}: address 0 → 0, never forwarded. Otherwise the lowest-index entry k with we=1 and waddr=s supplies wdata. If none matches, the regfile value is used. Older matching entries are ignored once a younger one matches.
- Load-use: the selected entry has is_load=1 and k < LOAD_LAT, and the source is used (rs_used_i / rt_used_i) → stallreq_o=1. No fall-through to older entries occurs.
- stallreq_o is gated by id_ce_o.
- Branches (opcode/funct/rt per MIPS32) use resolved operands, compared signed:
  - beq rs==rt; bne rs!=rt
  - bgez rs≥0; bgtz rs>0; blez rs≤0; bltz rs<0
  - bltzal / bgezal as bltz / bgez
  - j, jal, jr, jalr unconditional
- Targets:
  - conditional: pc+4 + sext(imm)<<2
  - j/jal: {pc+4[31:28], index, 2'b0}
  - jr/jalr: rs_val
  - 32-bit wrap-around ignored
- br_e_o = id_ce_o & ~stallreq_o & taken. br_addr_o = 0 when br_e_o=0.

## Timing
- Reset values: id_ce_o=0, id_pc_o=0, inst_o=0, br_e_o=0, br_addr_o=0, stallreq_o=0, hold_valid=0.
- Register/hold updates occur on the clk rising edge; all outputs other than the register contents are combinational in the same cycle.
- Latency: fetch → ID one cycle. The branch decision is made in the same cycle the instruction is valid in ID (delay-slot semantics are left to IF).
- Priority of simultaneous events: rst > flush > bubble > load > hold.
- Reset asserted mid-stall clears hold_valid. After reset, inst_o follows inst_i again.
- A flush while stallreq_o=1 drops the instruction, and stallreq_o falls in the next cycle.
- A stall lasting N cycles keeps inst_o constant for all N cycles, regardless of inst_i changes.
- NUM_FWD=1 and LOAD_LAT=0 are legal. LOAD_LAT=0 never stalls.

## Test plan
- Forward priority: entries 0 and 2 both write r8 (0x11, 0x33), ID reads `addu r9,r8,r0` → rs_val_o=0x11. With entry 0 invalid → 0x33.
- $0 guard: entry 0 writes r0 with 0xDEAD → rs_val_o=0 for an instruction reading r0.
- Load-use: entry 0 is a load to r4, `beq r4,r5` in ID → stallreq_o=1 and br_e_o=0. Next cycle entry 1 is the load with data 0x7 = r5 → br_e_o=1, br_addr_o=pc+4+(imm<<2).
- Hold across stall: stall[1]=Stop for 3 cycles while inst_i toggles → inst_o equals the first-cycle value. After release, the register loads the new pc.
- Signed branches: rs=0x80000000 → bltz taken, bgez not taken, blez taken, bgtz not taken. `jr` with forwarded rs=0x1FC00040 → br_addr_o=0x1FC00040.
- Reset/flush: assert rst during a 2-cycle stall → all outputs 0 next cycle. flush with ce=1 → id_ce_o=0, inst_o=0.
